// File: rtl/rotate_sdram_arbiter_if.sv
// Scandoubler vidin/vidout ports and SDRAM video port as seen by rotate_sdram_arbiter.
// The master modport is the arbiter; slave is the requester/controller side.
interface rotate_sdram_arbiter_if;
  logic        enable;
  logic        vidin_req;
  logic        vidin_frame;
  logic [9:0]  vidin_row;
  logic [9:0]  vidin_col;
  logic [15:0] vidin_d;
  logic        vidin_ack;
  logic        vidout_req;
  logic        vidout_frame;
  logic [9:0]  vidout_row;
  logic [9:0]  vidout_col;
  logic [15:0] vidout_d;
  logic        vidout_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_frame;
  logic [9:0]  mem_row;
  logic [9:0]  mem_col;
  logic [15:0] mem_wdata;
  logic        mem_accept;
  logic        mem_wstrobe;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  enable,
    input  vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    output vidin_ack,
    input  vidout_req, vidout_frame, vidout_row, vidout_col,
    output vidout_d, vidout_ack,
    output mem_req, mem_we, mem_frame, mem_row, mem_col, mem_wdata,
    input  mem_accept, mem_wstrobe, mem_rdata, mem_rvalid,
    output busy, timeout_err
  );

  modport slave (
    output enable,
    output vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    input  vidin_ack,
    output vidout_req, vidout_frame, vidout_row, vidout_col,
    input  vidout_d, vidout_ack,
    input  mem_req, mem_we, mem_frame, mem_row, mem_col, mem_wdata,
    output mem_accept, mem_wstrobe, mem_rdata, mem_rvalid,
    input  busy, timeout_err
  );
endinterface

// File: rtl/rotate_sdram_arbiter.sv
// Shares one SDRAM burst port between the scandoubler write stream and its read fetch,
// with write priority, a read anti-starvation limit and a per-burst watchdog.
module rotate_sdram_arbiter #(
  parameter int unsigned WR_LEN     = 16,
  parameter int unsigned RD_LEN     = 8,
  parameter int unsigned MAX_WR_RUN = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  rotate_sdram_arbiter_if.master        bus
);

  localparam int unsigned MAXLEN = (WR_LEN > RD_LEN) ? WR_LEN : RD_LEN;
  localparam int unsigned CNTW   = $clog2(MAXLEN) + 1;
  localparam int unsigned RUNW   = $clog2(MAX_WR_RUN + 1);
  localparam int unsigned WDW    = $clog2(TIMEOUT + 1);
  localparam logic [9:0]  COL_MASK = ~10'(WR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_DATA,
    S_RD_REQ,
    S_RD_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   word_q, word_d;
  logic [RUNW-1:0]   run_q, run_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic              grant_wr, grant_rd, wd_expired;

  logic              mem_req_q, mem_we_q, mem_frame_q, busy_q, timeout_err_q;
  logic [9:0]        mem_row_q, mem_col_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    run_d      = run_q;
    wd_d       = wd_q;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    wd_expired = (state_q != S_IDLE) && (wd_q == WDW'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: begin
        word_d = '0;
        if (bus.enable && bus.vidin_req &&
            !(bus.vidout_req && (run_q == RUNW'(MAX_WR_RUN)))) begin
          grant_wr = 1'b1;
          state_d  = S_WR_REQ;
        end else if (bus.enable && bus.vidout_req) begin
          grant_rd = 1'b1;
          state_d  = S_RD_REQ;
        end
        // A write run only counts against a read that is actually waiting.
        if (!bus.vidout_req || grant_rd) begin
          run_d = '0;
        end else if (grant_wr) begin
          run_d = run_q + 1'b1;
        end
      end
      S_WR_REQ: begin
        if (bus.mem_accept) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (bus.mem_wstrobe) begin
          if (word_q == CNTW'(WR_LEN - 1)) begin
            state_d = S_IDLE;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (bus.mem_accept) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (bus.mem_rvalid) begin
          if (word_q == CNTW'(RD_LEN - 1)) begin
            state_d = S_IDLE;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        word_d  = '0;
      end
    endcase

    wd_d = (state_q == S_IDLE) ? '0 : wd_q + 1'b1;
    if (wd_expired) begin
      state_d = S_IDLE;
      word_d  = '0;
    end
    if (state_d == S_IDLE) wd_d = '0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      run_q         <= '0;
      wd_q          <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_frame_q   <= 1'b0;
      mem_row_q     <= '0;
      mem_col_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      run_q         <= run_d;
      wd_q          <= wd_d;
      mem_req_q     <= (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
      busy_q        <= (state_d != S_IDLE);
      timeout_err_q <= timeout_err_q | wd_expired;
      if (grant_wr) begin
        mem_we_q    <= 1'b1;
        mem_frame_q <= bus.vidin_frame;
        mem_row_q   <= bus.vidin_row;
        mem_col_q   <= bus.vidin_col & COL_MASK;
      end else if (grant_rd) begin
        mem_we_q    <= 1'b0;
        mem_frame_q <= bus.vidout_frame;
        mem_row_q   <= bus.vidout_row;
        mem_col_q   <= bus.vidout_col;
      end
    end
  end

  // Data paths are combinational but gated by state so stray strobes never leak through.
  assign bus.mem_wdata   = (state_q == S_WR_DATA) ? bus.vidin_d : '0;
  assign bus.vidin_ack   = (state_q == S_WR_DATA) & bus.mem_wstrobe;
  assign bus.vidout_d    = (state_q == S_RD_DATA) ? bus.mem_rdata : '0;
  assign bus.vidout_ack  = (state_q == S_RD_DATA) & bus.mem_rvalid & bus.vidout_req;

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_frame   = mem_frame_q;
  assign bus.mem_row     = mem_row_q;
  assign bus.mem_col     = mem_col_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rotate_sdram_arbiter.sv
// Bench for rotate_sdram_arbiter: grant vectors from a table, data checked through queues,
// plus hand-written sequences for arbitration order, partial reads, watchdog and reset.
module tb_rotate_sdram_arbiter;

  localparam int unsigned WR_LEN = 16;
  localparam int unsigned RD_LEN = 8;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  logic [15:0] wq[$];
  logic [15:0] rq[$];
  logic        gq[$];

  rotate_sdram_arbiter_if bus();

  rotate_sdram_arbiter #(
    .WR_LEN    (WR_LEN),
    .RD_LEN    (RD_LEN),
    .MAX_WR_RUN(4),
    .TIMEOUT   (255)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic en, wr, rd;
    logic wfr; logic [9:0] wrow, wcol;
    logic rfr; logic [9:0] rrow, rcol;
    logic x_req, x_we, x_fr; logic [9:0] x_row, x_col;
    int unsigned dly;
  } vec_t;

  vec_t vt[6];

  task automatic nxt();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(bus.mem_req), 0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 0);
    chk({tag, "_mem_frame"}, 32'(bus.mem_frame), 0);
    chk({tag, "_mem_row"},   32'(bus.mem_row), 0);
    chk({tag, "_mem_col"},   32'(bus.mem_col), 0);
    chk({tag, "_vidin_ack"}, 32'(bus.vidin_ack), 0);
    chk({tag, "_vidout_ack"}, 32'(bus.vidout_ack), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_timeout"},   32'(bus.timeout_err), 0);
  endtask

  // Called at the first cycle of WR_REQ; returns in the IDLE cycle after the burst.
  task automatic wr_burst(input int unsigned dly);
    int unsigned acks = 0;
    logic [15:0] d, e;
    for (int k = 0; k < int'(dly); k++) begin
      bus.mem_wstrobe = 1'b1;
      #1 chk("stray_strobe_ack", 32'(bus.vidin_ack), 0);
      chk("wr_req_hold", 32'(bus.mem_req), 1);
      nxt();
    end
    bus.mem_wstrobe = 1'b0;
    bus.mem_accept  = 1'b1;
    nxt();
    bus.mem_accept = 1'b0;
    #1 chk("wr_req_drop", 32'(bus.mem_req), 0);
    for (int i = 0; i < int'(WR_LEN); i++) begin
      if (i % 5 == 2) begin
        bus.mem_wstrobe = 1'b0;
        nxt();
      end
      d = 16'($urandom);
      bus.vidin_d     = d;
      bus.mem_wstrobe = 1'b1;
      wq.push_back(d);
      #1;
      if (bus.vidin_ack) begin
        acks++;
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("wdata", 32'(bus.mem_wdata), 32'(e));
        end
      end
      nxt();
    end
    bus.mem_wstrobe = 1'b0;
    #1;
    chk("wr_acks", acks, WR_LEN);
    chk("wr_queue_empty", wq.size(), 0);
    chk("wr_done_idle", 32'(bus.busy), 0);
    wq.delete();
  endtask

  // keep = number of words during which vidout_req stays high.
  task automatic rd_burst(input int unsigned dly, input int unsigned keep);
    int unsigned acks = 0;
    logic [15:0] d, e;
    repeat (dly) nxt();
    bus.mem_accept = 1'b1;
    nxt();
    bus.mem_accept = 1'b0;
    #1 chk("rd_req_drop", 32'(bus.mem_req), 0);
    for (int i = 0; i < int'(RD_LEN); i++) begin
      chk("rd_busy", 32'(bus.busy), 1);
      bus.vidout_req = (i < int'(keep));
      d = 16'($urandom);
      bus.mem_rdata  = d;
      bus.mem_rvalid = 1'b1;
      if (bus.vidout_req) rq.push_back(d);
      #1;
      if (bus.vidout_ack) begin
        acks++;
        if (rq.size() > 0) begin
          e = rq.pop_front();
          chk("rdata", 32'(bus.vidout_d), 32'(e));
        end
      end
      nxt();
      bus.mem_rvalid = 1'b0;
    end
    #1;
    chk("rd_acks", acks, (keep < RD_LEN) ? keep : RD_LEN);
    chk("rd_queue_empty", rq.size(), 0);
    chk("rd_done_idle", 32'(bus.busy), 0);
    rq.delete();
    bus.vidout_req = (keep > RD_LEN);
  endtask

  // Acts as the controller for n grants, checking order against gq and the one-cycle IDLE gap.
  task automatic serve(input int n, input bit drop_wr);
    int unsigned gap;
    logic exp_we;
    for (int g = 0; g < n; g++) begin
      gap = 0;
      do begin
        nxt();
        gap++;
      end while (!bus.mem_req && gap < 8);
      #1;
      if (!bus.mem_req) begin
        chk("grant_seen", 32'(bus.mem_req), 1);
        return;
      end
      exp_we = (gq.size() > 0) ? gq.pop_front() : 1'bx;
      chk($sformatf("grant_order_%0d", g), 32'(bus.mem_we), 32'(exp_we));
      chk("b2b_gap", gap, 1);
      if (drop_wr) bus.vidin_req = 1'b0;
      if (bus.mem_we) wr_burst(1);
      else            rd_burst(0, 99);
      if (g == n - 1) begin
        bus.vidin_req  = 1'b0;
        bus.vidout_req = 1'b0;
      end
    end
  endtask

  initial begin
    int unsigned cnt;

    //       en wr rd  wfr wrow     wcol      rfr rrow     rcol      req we fr row      col      dly
    vt[0] = '{1, 1, 0,  0, 10'd5,   10'h023,  0, 10'd0,   10'd0,    1, 1, 0, 10'd5,   10'h020, 3};
    vt[1] = '{1, 0, 1,  0, 10'd0,   10'd0,    1, 10'h3FF, 10'h3FF,  1, 0, 1, 10'h3FF, 10'h3FF, 0};
    vt[2] = '{1, 1, 0,  1, 10'h200, 10'h3FF,  0, 10'd0,   10'd0,    1, 1, 1, 10'h200, 10'h3F0, 1};
    vt[3] = '{0, 1, 1,  1, 10'h001, 10'h001,  1, 10'h002, 10'h002,  0, 0, 0, 10'd0,   10'd0,   0};
    vt[4] = '{1, 1, 1,  0, 10'h011, 10'h00F,  1, 10'h155, 10'h2AA,  1, 1, 0, 10'h011, 10'h000, 2};
    vt[5] = '{1, 0, 1,  0, 10'd0,   10'd0,    0, 10'h0AB, 10'h105,  1, 0, 0, 10'h0AB, 10'h105, 5};

    bus.enable = 1'b1;  bus.vidin_req = 1'b1; bus.vidin_frame = 1'b1;
    bus.vidin_row = 10'd7; bus.vidin_col = 10'd9; bus.vidin_d = '0;
    bus.vidout_req = 1'b0; bus.vidout_frame = 1'b0; bus.vidout_row = '0; bus.vidout_col = '0;
    bus.mem_accept = 1'b0; bus.mem_wstrobe = 1'b0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;

    repeat (3) nxt();
    #1 chk_all_zero("reset");
    chk("reset_wdata", 32'(bus.mem_wdata), 0);
    bus.vidin_req = 1'b0;
    reset = 1'b0;
    nxt();

    for (int v = 0; v < 6; v++) begin
      bus.enable = vt[v].en; bus.vidin_req = vt[v].wr; bus.vidout_req = vt[v].rd;
      bus.vidin_frame = vt[v].wfr; bus.vidin_row = vt[v].wrow; bus.vidin_col = vt[v].wcol;
      bus.vidout_frame = vt[v].rfr; bus.vidout_row = vt[v].rrow; bus.vidout_col = vt[v].rcol;
      nxt();
      #1;
      chk($sformatf("v%0d_mem_req", v), 32'(bus.mem_req), 32'(vt[v].x_req));
      chk($sformatf("v%0d_busy", v), 32'(bus.busy), 32'(vt[v].x_req));
      if (vt[v].x_req) begin
        chk($sformatf("v%0d_mem_we", v), 32'(bus.mem_we), 32'(vt[v].x_we));
        chk($sformatf("v%0d_mem_frame", v), 32'(bus.mem_frame), 32'(vt[v].x_fr));
        chk($sformatf("v%0d_mem_row", v), 32'(bus.mem_row), 32'(vt[v].x_row));
        chk($sformatf("v%0d_mem_col", v), 32'(bus.mem_col), 32'(vt[v].x_col));
        bus.vidin_req = 1'b0; bus.vidout_req = 1'b0;
        if (vt[v].x_we) wr_burst(vt[v].dly);
        else            rd_burst(vt[v].dly, RD_LEN);
      end else begin
        bus.mem_accept = 1'b1;
        nxt();
        bus.mem_accept = 1'b0;
        #1 chk("idle_accept_busy", 32'(bus.busy), 0);
        chk("disabled_no_req", 32'(bus.mem_req), 0);
        nxt();
        #1 chk("disabled_no_req2", 32'(bus.mem_req), 0);
        bus.vidin_req = 1'b0; bus.vidout_req = 1'b0; bus.enable = 1'b1;
      end
    end

    // Simultaneous requests: write first, read after a single IDLE cycle.
    gq.push_back(1'b1); gq.push_back(1'b0);
    bus.vidin_req = 1'b1; bus.vidout_req = 1'b1;
    serve(2, 1'b1);

    // Anti-starvation: four writes then a read while both stay pending.
    gq.delete();
    for (int i = 0; i < 10; i++) gq.push_back((i % 5) != 4);
    bus.vidin_req = 1'b1; bus.vidout_req = 1'b1;
    serve(10, 1'b0);
    chk("grant_queue_drained", gq.size(), 0);

    // Partial read: requester drops after the 3rd word, burst still runs to 8 words.
    bus.vidout_req = 1'b1;
    nxt();
    #1 chk("partial_grant_rd", 32'(bus.mem_req & ~bus.mem_we), 1);
    rd_burst(2, 3);
    chk("partial_no_regrant", 32'(bus.mem_req), 0);

    // Watchdog: read granted, controller never accepts.
    bus.vidout_req = 1'b1;
    nxt();
    #1 chk("wd_grant", 32'(bus.mem_req), 1);
    bus.vidout_req = 1'b0;
    cnt = 1;
    while (cnt < 400) begin
      nxt();
      #1;
      if (!bus.mem_req) break;
      cnt++;
    end
    chk("wd_req_cycles", cnt, 255);
    chk("wd_idle", 32'(bus.busy), 0);
    chk("wd_timeout_err", 32'(bus.timeout_err), 1);
    repeat (20) nxt();
    #1 chk("wd_timeout_sticky", 32'(bus.timeout_err), 1);
    reset = 1'b1;
    #1 chk("wd_cleared_by_reset", 32'(bus.timeout_err), 0);
    nxt();
    reset = 1'b0;

    // Reset asserted mid write burst between clock edges.
    bus.vidin_req = 1'b1; bus.vidin_frame = 1'b1; bus.vidin_row = 10'd5; bus.vidin_col = 10'h023;
    nxt();
    bus.vidin_req  = 1'b0;
    bus.mem_accept = 1'b1;
    nxt();
    bus.mem_accept  = 1'b0;
    bus.mem_wstrobe = 1'b1;
    bus.vidin_d     = 16'hBEEF;
    #1 chk("midburst_ack_before_reset", 32'(bus.vidin_ack), 1);
    chk("midburst_we_before_reset", 32'(bus.mem_we), 1);
    reset = 1'b1;
    #1 chk_all_zero("async_reset");
    chk("async_reset_wdata", 32'(bus.mem_wdata), 0);
    bus.mem_wstrobe = 1'b0;
    nxt();
    reset = 1'b0;
    repeat (3) nxt();
    #1 chk("post_reset_idle", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
